// File: rtl/vdp_super_pkg.sv
// Shared types and constants for the super-res VRAM fetch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vdp_super_pkg;

  // Width of a VRAM dword address.
  localparam int VRAM_DWORD_AW = 17;

  // Default cx value that opens the per-line refresh slot.
  localparam int REFRESH_CX_DFLT = 723;

  // Default budget, in clocks, from address capture to read data delivered.
  localparam int LATENCY_BUDGET_DFLT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RFSH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/vdp_super_vram_fetch_if.sv
// SDRAM controller request/response bus for the super-res VRAM fetch stage.
// Latency: n/a (wiring only). master = fetch stage, slave = SDRAM controller.
// Backpressure: requests are held by the master until mem_ack; read data is one-shot (no ready).
interface vdp_super_vram_fetch_if;

  logic                                    mem_req;      // read request
  logic                                    mem_refresh;  // refresh request
  logic [vdp_super_pkg::VRAM_DWORD_AW-1:0] mem_addr;     // dword address of current request
  logic                                    mem_ack;      // request accepted (read or refresh)
  logic                                    mem_rd_valid; // mem_rd_data valid for one clock
  logic [31:0]                             mem_rd_data;  // read data

  modport master (
    output mem_req,
    output mem_refresh,
    output mem_addr,
    input  mem_ack,
    input  mem_rd_valid,
    input  mem_rd_data
  );

  modport slave (
    input  mem_req,
    input  mem_refresh,
    input  mem_addr,
    output mem_ack,
    output mem_rd_valid,
    output mem_rd_data
  );

endinterface

// File: rtl/vdp_super_vram_fetch.sv
// Issues one SDRAM read per change of the super-res dword address and a once-per-line refresh.
// Latency: capture 1 clk after address change, data on vrm_32 the clk after mem_rd_valid.
// Backpressure: mem_req/mem_refresh held until mem_ack; newer addresses supersede un-issued ones.
// Ports: clk, reset_n (async active-low), vdp_super (enable), cx (pixel counter),
//   vram_addr (dword address in), vrm_32 (read data out), underrun (sticky budget miss),
//   mem (controller bus, master side).
module vdp_super_vram_fetch
  import vdp_super_pkg::*;
#(
  parameter int REFRESH_CX     = REFRESH_CX_DFLT,
  parameter int LATENCY_BUDGET = LATENCY_BUDGET_DFLT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vdp_super,
  input  logic [10:0]              cx,
  input  logic [VRAM_DWORD_AW-1:0] vram_addr,
  output logic [31:0]              vrm_32,
  output logic                     underrun,
  vdp_super_vram_fetch_if.master   mem
);

  fetch_state_t             state;
  logic [VRAM_DWORD_AW-1:0] last_addr;
  logic                     pending;       // force a fetch of whatever address is present
  logic                     change_pend;   // address moved while busy
  logic                     refresh_pend;  // refresh slot seen but not yet acked
  logic                     cx_at_slot_q;  // cx sat on the refresh slot last clock
  logic [2:0]               budget;

  logic addr_diff;
  logic change;
  logic rfsh_hit;

  assign addr_diff = (vram_addr != last_addr);
  assign change    = addr_diff | pending | change_pend;
  // Rising-edge detect on the slot so a cx held on REFRESH_CX still yields one refresh.
  assign rfsh_hit  = (cx == 11'(REFRESH_CX)) && !cx_at_slot_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      last_addr       <= '0;
      pending         <= 1'b1;
      change_pend     <= 1'b0;
      refresh_pend    <= 1'b0;
      cx_at_slot_q    <= 1'b0;
      budget          <= 3'd0;
      vrm_32          <= 32'd0;
      underrun        <= 1'b0;
      mem.mem_req     <= 1'b0;
      mem.mem_refresh <= 1'b0;
      mem.mem_addr    <= '0;
    end else begin
      cx_at_slot_q <= (cx == 11'(REFRESH_CX));

      if (rfsh_hit && vdp_super) begin
        refresh_pend <= 1'b1;
      end

      if (state != IDLE && addr_diff) begin
        change_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!vdp_super) begin
            vrm_32       <= 32'd0;
            pending      <= 1'b1;
            change_pend  <= 1'b0;
            refresh_pend <= 1'b0;
          end else if (change) begin
            state        <= REQ;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= vram_addr;
            last_addr    <= vram_addr;
            pending      <= 1'b0;
            change_pend  <= 1'b0;
            budget       <= 3'd1;
          end else if (rfsh_hit || refresh_pend) begin
            state           <= RFSH;
            mem.mem_refresh <= 1'b1;
          end
        end

        REQ: begin
          if (budget != 3'd7) budget <= budget + 3'd1;
          if (budget >= 3'(LATENCY_BUDGET)) underrun <= 1'b1;
          if (mem.mem_ack) begin
            // Once accepted the read must complete even if disabled meanwhile.
            mem.mem_req <= 1'b0;
            state       <= WAIT;
          end else if (!vdp_super) begin
            mem.mem_req <= 1'b0;
            state       <= IDLE;
          end
        end

        WAIT: begin
          if (mem.mem_rd_valid) begin
            if (vdp_super) begin
              vrm_32 <= mem.mem_rd_data;
            end
            if (vdp_super && change) begin
              // Back-to-back: issue the newest address without an IDLE bubble.
              state        <= REQ;
              mem.mem_req  <= 1'b1;
              mem.mem_addr <= vram_addr;
              last_addr    <= vram_addr;
              pending      <= 1'b0;
              change_pend  <= 1'b0;
              budget       <= 3'd1;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (budget != 3'd7) budget <= budget + 3'd1;
            if (budget >= 3'(LATENCY_BUDGET)) underrun <= 1'b1;
          end
        end

        RFSH: begin
          if (mem.mem_ack || !vdp_super) begin
            mem.mem_refresh <= 1'b0;
            refresh_pend    <= 1'b0;
            state           <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_super_vram_fetch.sv
// Directed bench for vdp_super_vram_fetch: bench plays the SDRAM controller by hand.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: ack/valid timing chosen per step to exercise the latency budget.
module tb_vdp_super_vram_fetch;

  logic        clk;
  logic        reset_n;
  logic        vdp_super;
  logic [10:0] cx;
  logic [16:0] vram_addr;
  logic [31:0] vrm_32;
  logic        underrun;

  vdp_super_vram_fetch_if mem_if ();

  vdp_super_vram_fetch dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .vdp_super (vdp_super),
    .cx        (cx),
    .vram_addr (vram_addr),
    .vrm_32    (vrm_32),
    .underrun  (underrun),
    .mem       (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [31:0] exp_vrm;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full read: address change, ack the clock after mem_req, data after 1+extra more clocks.
  task automatic fetch(input logic [16:0] a, input logic [31:0] d, input int extra);
    vram_addr = a;
    tick();
    chk("req_up", {31'd0, mem_if.mem_req}, 32'd1);
    chk("req_addr", {15'd0, mem_if.mem_addr}, {15'd0, a});
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("req_down", {31'd0, mem_if.mem_req}, 32'd0);
    chk("no_rfsh", {31'd0, mem_if.mem_refresh}, 32'd0);
    repeat (1 + extra) tick();
    mem_if.mem_rd_valid = 1'b1;
    mem_if.mem_rd_data  = d;
    tick();
    mem_if.mem_rd_valid = 1'b0;
    mem_if.mem_rd_data  = 32'h0;
    exp_vrm = d;
    chk("vrm", vrm_32, exp_vrm);
  endtask

  initial begin
    reset_n             = 1'b0;
    vdp_super           = 1'b1;
    cx                  = 11'd0;
    vram_addr           = 17'd0;
    mem_if.mem_ack      = 1'b0;
    mem_if.mem_rd_valid = 1'b0;
    mem_if.mem_rd_data  = 32'h0;
    repeat (3) tick();

    // Reset values
    chk("rst_vrm", vrm_32, 32'd0);
    chk("rst_req", {31'd0, mem_if.mem_req}, 32'd0);
    chk("rst_rfsh", {31'd0, mem_if.mem_refresh}, 32'd0);
    chk("rst_addr", {15'd0, mem_if.mem_addr}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);

    // First fetch after reset
    reset_n = 1'b1;
    fetch(17'h00010, 32'hDEADBEEF, 0);
    chk("t1_underrun", {31'd0, underrun}, 32'd0);

    // 180 sequential dwords, 4 clocks each
    for (int i = 0; i < 180; i++) begin
      fetch(17'(17'h00011 + i), 32'h5A000000 + 32'(i) * 32'h00010003, 0);
    end
    chk("seq_underrun", {31'd0, underrun}, 32'd0);

    // Address wrap
    fetch(17'h1FFFF, 32'h1111FFFF, 0);
    fetch(17'h00000, 32'h22220000, 0);

    // Data on the last clock of the budget: no underrun
    fetch(17'h00020, 32'hCAFE0020, 1);
    chk("edge_underrun", {31'd0, underrun}, 32'd0);

    // Stray valid in IDLE is ignored
    mem_if.mem_rd_valid = 1'b1;
    mem_if.mem_rd_data  = 32'hBADBAD00;
    tick();
    mem_if.mem_rd_valid = 1'b0;
    chk("stray_vrm", vrm_32, exp_vrm);
    chk("stray_req", {31'd0, mem_if.mem_req}, 32'd0);

    // Refresh slot in IDLE, cx held on the slot: one refresh only
    cx = 11'd723;
    tick();
    chk("rf_idle_up", {31'd0, mem_if.mem_refresh}, 32'd1);
    chk("rf_idle_noreq", {31'd0, mem_if.mem_req}, 32'd0);
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("rf_idle_down", {31'd0, mem_if.mem_refresh}, 32'd0);
    tick();
    chk("rf_idle_once", {31'd0, mem_if.mem_refresh}, 32'd0);
    cx = 11'd0;
    tick();

    // Refresh slot while WAIT busy: deferred to first clock after IDLE
    vram_addr = 17'h00030;
    tick();
    chk("rfb_req", {31'd0, mem_if.mem_req}, 32'd1);
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    cx = 11'd723;
    tick();
    cx = 11'd724;
    chk("rfb_busy", {31'd0, mem_if.mem_refresh}, 32'd0);
    mem_if.mem_rd_valid = 1'b1;
    mem_if.mem_rd_data  = 32'h0000A030;
    tick();
    mem_if.mem_rd_valid = 1'b0;
    exp_vrm = 32'h0000A030;
    chk("rfb_vrm", vrm_32, exp_vrm);
    chk("rfb_idle", {31'd0, mem_if.mem_refresh}, 32'd0);
    tick();
    chk("rfb_up", {31'd0, mem_if.mem_refresh}, 32'd1);
    chk("rfb_noreq", {31'd0, mem_if.mem_req}, 32'd0);
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("rfb_down", {31'd0, mem_if.mem_refresh}, 32'd0);
    cx = 11'd0;
    repeat (3) tick();
    chk("rfb_once", {31'd0, mem_if.mem_refresh}, 32'd0);
    chk("rfb_noreq2", {31'd0, mem_if.mem_req}, 32'd0);

    // Three changes during WAIT: only the newest is issued next
    vram_addr = 17'h000FF;
    tick();
    chk("co_addr0", {15'd0, mem_if.mem_addr}, 32'h000FF);
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    vram_addr = 17'h00100;
    tick();
    vram_addr = 17'h00101;
    tick();
    vram_addr = 17'h00102;
    mem_if.mem_rd_valid = 1'b1;
    mem_if.mem_rd_data  = 32'h000000FF;
    tick();
    mem_if.mem_rd_valid = 1'b0;
    exp_vrm = 32'h000000FF;
    chk("co_vrm0", vrm_32, exp_vrm);
    chk("co_req", {31'd0, mem_if.mem_req}, 32'd1);
    chk("co_addr", {15'd0, mem_if.mem_addr}, 32'h00102);
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    tick();
    mem_if.mem_rd_valid = 1'b1;
    mem_if.mem_rd_data  = 32'h00000102;
    tick();
    mem_if.mem_rd_valid = 1'b0;
    exp_vrm = 32'h00000102;
    chk("co_vrm1", vrm_32, exp_vrm);
    repeat (2) tick();
    chk("co_noreq", {31'd0, mem_if.mem_req}, 32'd0);
    chk("co_underrun", {31'd0, underrun}, 32'd0);

    // Late data: underrun set and sticky, late data still delivered
    fetch(17'h00500, 32'h1A7E0500, 2);
    chk("ur_set", {31'd0, underrun}, 32'd1);
    fetch(17'h00501, 32'h00000501, 0);
    chk("ur_sticky", {31'd0, underrun}, 32'd1);

    // Disable during WAIT: data discarded, vrm cleared, same address refetched
    vram_addr = 17'h00200;
    tick();
    chk("dis_req", {31'd0, mem_if.mem_req}, 32'd1);
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    vdp_super = 1'b0;
    tick();
    mem_if.mem_rd_valid = 1'b1;
    mem_if.mem_rd_data  = 32'hD15CA4D0;
    tick();
    mem_if.mem_rd_valid = 1'b0;
    chk("dis_keep", vrm_32, exp_vrm);
    tick();
    chk("dis_vrm0", vrm_32, 32'd0);
    chk("dis_noreq", {31'd0, mem_if.mem_req}, 32'd0);
    chk("dis_ur_held", {31'd0, underrun}, 32'd1);
    vdp_super = 1'b1;
    fetch(17'h00200, 32'h00000200, 0);

    // Disable in REQ before ack: request withdrawn
    vram_addr = 17'h00300;
    tick();
    chk("ab_req", {31'd0, mem_if.mem_req}, 32'd1);
    vdp_super = 1'b0;
    tick();
    chk("ab_drop", {31'd0, mem_if.mem_req}, 32'd0);
    tick();
    vdp_super = 1'b1;
    fetch(17'h00300, 32'h00000300, 0);

    // Reset mid-transaction
    vram_addr = 17'h00400;
    tick();
    chk("mr_req", {31'd0, mem_if.mem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mr_req0", {31'd0, mem_if.mem_req}, 32'd0);
    chk("mr_addr0", {15'd0, mem_if.mem_addr}, 32'd0);
    chk("mr_vrm0", vrm_32, 32'd0);
    chk("mr_ur0", {31'd0, underrun}, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
